// File: rtl/spi_parallel_mem_link_if.sv
// Bus bundle for spi_parallel_mem_link: SPI command/response words and the RAM load/read port.
// o_valid exists only when SPI_LINK_VALID_STROBE_EN is defined.
interface spi_parallel_mem_link_if #(
    parameter int NB_BITS  = 32,
    parameter int NB_DEPTH = 10
);
    logic [NB_BITS-1:0]  i_MOSI;
    logic                i_SCLK;
    logic                i_cs;
    logic [NB_BITS-1:0]  i_data;
    logic [NB_BITS-1:0]  o_data;
    logic [NB_BITS-1:0]  o_MISO;
`ifdef SPI_LINK_VALID_STROBE_EN
    logic                o_valid;
`endif

    logic [NB_DEPTH-1:0] i_ram_addr;
    logic [NB_BITS-1:0]  i_ram_data;
    logic                i_ram_wea;
    logic                i_ram_flush;
    logic                i_ram_hold_n;
    logic [NB_BITS-1:0]  o_ram_data;

`ifdef SPI_LINK_VALID_STROBE_EN
    modport master (
        output i_MOSI, i_SCLK, i_cs, i_data,
        output i_ram_addr, i_ram_data, i_ram_wea, i_ram_flush, i_ram_hold_n,
        input  o_data, o_MISO, o_valid, o_ram_data
    );

    modport slave (
        input  i_MOSI, i_SCLK, i_cs, i_data,
        input  i_ram_addr, i_ram_data, i_ram_wea, i_ram_flush, i_ram_hold_n,
        output o_data, o_MISO, o_valid, o_ram_data
    );
`else
    modport master (
        output i_MOSI, i_SCLK, i_cs, i_data,
        output i_ram_addr, i_ram_data, i_ram_wea, i_ram_flush, i_ram_hold_n,
        input  o_data, o_MISO, o_ram_data
    );

    modport slave (
        input  i_MOSI, i_SCLK, i_cs, i_data,
        input  i_ram_addr, i_ram_data, i_ram_wea, i_ram_flush, i_ram_hold_n,
        output o_data, o_MISO, o_ram_data
    );
`endif
endinterface

// File: rtl/spi_parallel_mem_link.sv
// Debug/load link: parallel-word SPI-style slave plus read-first instruction RAM with flush/hold.
// Optional SPI_LINK_VALID_STROBE_EN adds a one-cycle o_valid pulse on each command capture.
module spi_parallel_mem_link #(
    parameter int                 NB_BITS  = 32,
    parameter int                 NB_DEPTH = 10,
    parameter logic [NB_BITS-1:0] SSL      = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    spi_parallel_mem_link_if.slave bus
);
    localparam int DEPTH = 2 ** NB_DEPTH;

    // SPI slave
    logic [2:0]         sclk_sync_q, sclk_sync_d;
    logic [1:0]         cs_sync_q, cs_sync_d;
    logic               sclk_rise, sclk_fall, cs_active;
    logic [NB_BITS-1:0] data_q, data_d;
    logic [NB_BITS-1:0] miso_q, miso_d;
`ifdef SPI_LINK_VALID_STROBE_EN
    logic               valid_q, valid_d;
`endif

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], bus.i_SCLK};
        cs_sync_d   = {cs_sync_q[0], bus.i_cs};
        sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
        sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
        cs_active   = cs_sync_q[1];
        data_d      = data_q;
        miso_d      = miso_q;
`ifdef SPI_LINK_VALID_STROBE_EN
        valid_d     = 1'b0;
`endif
        // Deselect clears the command every cycle and beats any SCLK edge seen in the same cycle.
        if (!cs_active) begin
            data_d = '0;
        end else begin
            if (sclk_rise) begin
                data_d = bus.i_MOSI;
`ifdef SPI_LINK_VALID_STROBE_EN
                valid_d = 1'b1;
`endif
            end
            if (sclk_fall) begin
                miso_d = bus.i_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, which keeps the synchroniser chain a true shift register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            data_q      <= '0;
            miso_q      <= '0;
`ifdef SPI_LINK_VALID_STROBE_EN
            valid_q     <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            data_q      <= data_d;
            miso_q      <= miso_d;
`ifdef SPI_LINK_VALID_STROBE_EN
            valid_q     <= valid_d;
`endif
        end
    end

    assign bus.o_data = data_q;
    assign bus.o_MISO = miso_q;
`ifdef SPI_LINK_VALID_STROBE_EN
    assign bus.o_valid = valid_q;
`endif

    // Instruction RAM; power-up contents come from the device configuration (all zero).
    logic [NB_BITS-1:0] mem [DEPTH];
    logic [NB_BITS-1:0] ram_q, ram_d;

    // NOTE: the storage array has no reset branch so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge i_clk) begin
        if (bus.i_ram_wea) begin
            mem[bus.i_ram_addr] <= bus.i_ram_data;
        end
    end

    // Reading mem here sees the pre-edge contents, giving read-first behaviour on a same-address write.
    always_comb begin
        ram_d = ram_q;
        if (bus.i_ram_flush) begin
            ram_d = SSL;
        end else if (bus.i_ram_hold_n) begin
            ram_d = mem[bus.i_ram_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ram_q <= SSL;
        end else begin
            ram_q <= ram_d;
        end
    end

    assign bus.o_ram_data = ram_q;

endmodule

// File: tb/tb_spi_parallel_mem_link.sv
// Self-checking bench for spi_parallel_mem_link: directed and randomized SPI words and RAM traffic
// against a value-level reference model.
module tb_spi_parallel_mem_link;
    localparam int                 NB_BITS  = 32;
    localparam int                 NB_DEPTH = 10;
    localparam logic [NB_BITS-1:0] SSL      = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_parallel_mem_link_if #(.NB_BITS(NB_BITS), .NB_DEPTH(NB_DEPTH)) bus ();

    spi_parallel_mem_link #(
        .NB_BITS (NB_BITS),
        .NB_DEPTH(NB_DEPTH),
        .SSL     (SSL)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what the master should see, and what the RAM holds.
    logic [NB_BITS-1:0] exp_data;
    logic [NB_BITS-1:0] exp_miso;
    logic [NB_BITS-1:0] exp_ram;
    logic [NB_BITS-1:0] ref_mem [2**NB_DEPTH];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI word: 3 clk high, 3 clk low. Checks exact 3-edge latency of both edges.
    task automatic spi_word(input logic [NB_BITS-1:0] mosi, input logic [NB_BITS-1:0] resp,
                            input bit cs_on, input string tag);
        bus.i_MOSI = mosi;
        bus.i_SCLK = 1'b1;
        tick(2);
        checks++;
        if (bus.o_data !== exp_data) begin
            errors++;
            $display("FAIL %s rise_early o_data got %h want %h", tag, bus.o_data, exp_data);
        end
`ifdef SPI_LINK_VALID_STROBE_EN
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_early got %b want 0", tag, bus.o_valid);
        end
`endif
        tick(1);
        if (cs_on) exp_data = mosi;
        checks++;
        if (bus.o_data !== exp_data) begin
            errors++;
            $display("FAIL %s rise o_data got %h want %h", tag, bus.o_data, exp_data);
        end
        checks++;
        if (bus.o_MISO !== exp_miso) begin
            errors++;
            $display("FAIL %s rise o_MISO got %h want %h", tag, bus.o_MISO, exp_miso);
        end
`ifdef SPI_LINK_VALID_STROBE_EN
        checks++;
        if (bus.o_valid !== cs_on) begin
            errors++;
            $display("FAIL %s valid got %b want %b", tag, bus.o_valid, cs_on);
        end
`endif
        bus.i_data = resp;
        bus.i_SCLK = 1'b0;
        tick(2);
        checks++;
        if (bus.o_MISO !== exp_miso) begin
            errors++;
            $display("FAIL %s fall_early o_MISO got %h want %h", tag, bus.o_MISO, exp_miso);
        end
        tick(1);
        if (cs_on) exp_miso = resp;
        checks++;
        if (bus.o_MISO !== exp_miso) begin
            errors++;
            $display("FAIL %s fall o_MISO got %h want %h", tag, bus.o_MISO, exp_miso);
        end
        checks++;
        if (bus.o_data !== exp_data) begin
            errors++;
            $display("FAIL %s fall o_data got %h want %h", tag, bus.o_data, exp_data);
        end
    endtask

    // One RAM cycle: drive at negedge, update the model at the edge, return at the next negedge.
    task automatic ram_op(input logic [NB_DEPTH-1:0] addr, input logic [NB_BITS-1:0] data,
                          input logic wea, input logic flush, input logic hold_n);
        bus.i_ram_addr   = addr;
        bus.i_ram_data   = data;
        bus.i_ram_wea    = wea;
        bus.i_ram_flush  = flush;
        bus.i_ram_hold_n = hold_n;
        @(posedge clk);
        if (flush)       exp_ram = SSL;
        else if (hold_n) exp_ram = ref_mem[addr];
        if (wea)         ref_mem[addr] = data;
        @(negedge clk);
        bus.i_ram_wea = 1'b0;
    endtask

    task automatic check_ram(input logic [NB_BITS-1:0] want, input string tag);
        checks++;
        if (bus.o_ram_data !== want) begin
            errors++;
            $display("FAIL %s o_ram_data got %h want %h", tag, bus.o_ram_data, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(4);
        checks++;
        if (bus.o_data !== '0) begin
            errors++;
            $display("FAIL reset o_data got %h want 0", bus.o_data);
        end
        checks++;
        if (bus.o_MISO !== '0) begin
            errors++;
            $display("FAIL reset o_MISO got %h want 0", bus.o_MISO);
        end
        check_ram(SSL, "reset");
        rst = 1'b0;
        exp_data = '0;
        exp_miso = '0;
        exp_ram  = SSL;
    endtask

    task automatic test_capture_response();
        bus.i_cs = 1'b1;
        tick(3);
        spi_word(32'h1000FFFF, 32'h000003FF, 1'b1, "capture0");
        spi_word(32'h2000F0F0, 32'h000003FF, 1'b1, "capture1");
        for (int i = 0; i < 3; i++) spi_word($urandom, $urandom, 1'b1, "capture_rnd");
    endtask

    task automatic test_deselect();
        bus.i_cs = 1'b0;
        tick(3);
        exp_data = '0;
        checks++;
        if (bus.o_data !== '0) begin
            errors++;
            $display("FAIL deselect o_data got %h want 0", bus.o_data);
        end
        checks++;
        if (bus.o_MISO !== exp_miso) begin
            errors++;
            $display("FAIL deselect o_MISO got %h want %h", bus.o_MISO, exp_miso);
        end
        for (int i = 0; i < 3; i++) spi_word($urandom, $urandom, 1'b0, "deselect_toggle");
    endtask

    task automatic test_cs_race();
        logic [NB_BITS-1:0] w;
        bus.i_cs = 1'b1;
        tick(3);
        spi_word($urandom | 32'h1, $urandom, 1'b1, "race_setup");
        // cs drops together with an SCLK rise: the capture must lose.
        w = $urandom;
        bus.i_MOSI = w;
        bus.i_SCLK = 1'b1;
        bus.i_cs   = 1'b0;
        tick(3);
        exp_data = '0;
        checks++;
        if (bus.o_data !== '0) begin
            errors++;
            $display("FAIL race_rise o_data got %h want 0", bus.o_data);
        end
        bus.i_SCLK = 1'b0;
        tick(3);
        // cs drops together with an SCLK fall: o_MISO must not load.
        bus.i_cs = 1'b1;
        tick(3);
        w = $urandom | 32'h1;
        bus.i_MOSI = w;
        bus.i_SCLK = 1'b1;
        tick(3);
        checks++;
        if (bus.o_data !== w) begin
            errors++;
            $display("FAIL race_recapture o_data got %h want %h", bus.o_data, w);
        end
        bus.i_data = ~exp_miso;
        bus.i_SCLK = 1'b0;
        bus.i_cs   = 1'b0;
        tick(3);
        checks++;
        if (bus.o_MISO !== exp_miso) begin
            errors++;
            $display("FAIL race_fall o_MISO got %h want %h", bus.o_MISO, exp_miso);
        end
        checks++;
        if (bus.o_data !== '0) begin
            errors++;
            $display("FAIL race_fall o_data got %h want 0", bus.o_data);
        end
    endtask

    task automatic test_random_spi();
        bus.i_cs = 1'b1;
        tick(3);
        for (int i = 0; i < 20; i++) spi_word($urandom, $urandom, 1'b1, "spi_rnd");
        bus.i_cs = 1'b0;
        tick(3);
        exp_data = '0;
    endtask

    task automatic test_ram_directed();
        ram_op(10'h000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        check_ram(32'h00000000, "ram_write_held");
        ram_op(10'h000, 32'h0, 1'b0, 1'b0, 1'b1);
        check_ram(32'hFFFFFFFF, "ram_read");
        ram_op(10'h000, 32'h12345678, 1'b1, 1'b0, 1'b1);
        check_ram(32'hFFFFFFFF, "ram_read_first");
        ram_op(10'h000, 32'h0, 1'b0, 1'b0, 1'b1);
        check_ram(32'h12345678, "ram_new_visible");
        ram_op(10'h005, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
        check_ram(32'h12345678, "ram_hold_during_write");
        ram_op(10'h000, 32'h0, 1'b0, 1'b1, 1'b1);
        check_ram(SSL, "ram_flush");
        ram_op(10'h005, 32'h0, 1'b0, 1'b0, 1'b1);
        check_ram(32'hA5A5A5A5, "ram_read5");
        ram_op(10'h000, 32'h0, 1'b0, 1'b0, 1'b0);
        check_ram(32'hA5A5A5A5, "ram_hold_addr_change");
        ram_op(10'h000, 32'h0, 1'b0, 1'b1, 1'b0);
        check_ram(SSL, "ram_flush_over_hold");
        ram_op(10'h3FF, 32'hC0DE0001, 1'b1, 1'b0, 1'b0);
        ram_op(10'h3FF, 32'h0, 1'b0, 1'b0, 1'b1);
        check_ram(32'hC0DE0001, "ram_top_addr");
    endtask

    task automatic test_reset_keeps_mem();
        rst = 1'b1;
        bus.i_ram_addr   = 10'h005;
        bus.i_ram_hold_n = 1'b1;
        tick(2);
        check_ram(SSL, "rst_ram_out");
        rst = 1'b0;
        exp_ram = SSL;
        ram_op(10'h005, 32'h0, 1'b0, 1'b0, 1'b1);
        check_ram(32'hA5A5A5A5, "rst_mem_kept");
    endtask

    task automatic test_random_ram();
        for (int a = 0; a < 16; a++) ram_op(a[NB_DEPTH-1:0], $urandom, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            ram_op(NB_DEPTH'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
            check_ram(exp_ram, "ram_rnd");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2**NB_DEPTH; i++) ref_mem[i] = '0;
        bus.i_MOSI       = '0;
        bus.i_SCLK       = 1'b0;
        bus.i_cs         = 1'b0;
        bus.i_data       = '0;
        bus.i_ram_addr   = '0;
        bus.i_ram_data   = '0;
        bus.i_ram_wea    = 1'b0;
        bus.i_ram_flush  = 1'b0;
        bus.i_ram_hold_n = 1'b1;
        exp_data = '0;
        exp_miso = '0;
        exp_ram  = SSL;

        test_reset();
        test_capture_response();
        test_deselect();
        test_cs_race();
        test_random_spi();
        test_ram_directed();
        test_reset_keeps_mem();
        test_random_ram();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_parallel_mem_link.md
Name: spi_parallel_mem_link

Overview:
- Debug/load link block with two independent sub-units sharing one clock and reset.
- Parallel-word SPI-style slave: captures a full 32-bit command word (i_MOSI) on each SCLK rising edge and returns a full response word (o_MISO) on each SCLK falling edge.
- Single-port RAM with registered output, flush-to-NOP and hold control, used as the instruction memory that the link loads and reads back.

Parameters:
- NB_BITS, 32, SPI word width and RAM data width.
- NB_DEPTH, 10, RAM address width; RAM holds 2**NB_DEPTH words.
- SSL, 0, word driven on the RAM output at reset and on flush (NOP "sll $0,$0,0").

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_MOSI  in  NB_BITS  parallel command word from master; stable around SCLK rise.
- i_SCLK  in  1  master strobe, asynchronous to i_clk.
- i_cs  in  1  chip select, active-high, asynchronous.
- i_data  in  NB_BITS  response word supplied by downstream logic.
- o_data  out  NB_BITS  last captured command word.
- o_MISO  out  NB_BITS  response word presented to master.
- i_ram_addr  in  NB_DEPTH  RAM address.
- i_ram_data  in  NB_BITS  RAM write data.
- i_ram_wea  in  1  RAM write enable.
- i_ram_flush  in  1  force RAM output register to SSL.
- i_ram_hold_n  in  1  RAM output register update enable (1 = update, 0 = hold).
- o_ram_data  out  NB_BITS  registered RAM read data.

Behaviour:
- SPI synchroniser: i_SCLK and i_cs each pass through 2 flops, plus a third SCLK stage for edge detection. rise = s2 & ~s3; fall = ~s2 & s3.
- Reset: o_data = 0, o_MISO = 0, all sync flops = 0.
- SCLK rise with synced cs = 1: o_data <= i_MOSI, sampled at the detecting clock edge.
  - o_data updates on the 3rd i_clk edge after SCLK rises.
  - o_data then holds until the next rise.
  - Downstream logic must tolerate a held command; a held write repeats an idempotent write.
- SCLK fall with synced cs = 1: o_MISO <= i_data, on the 3rd i_clk edge after SCLK falls. It therefore reflects the response to the word captured on the preceding rise.
- Synced cs = 0:
  - o_data <= 0 every cycle, so no stale command persists after deselect.
  - o_MISO holds its last value.
  - SCLK edges are ignored.
- cs falling in the same cycle as a detected SCLK edge: cs = 0 wins; o_data clears and o_MISO is not loaded.
- SCLK glitches shorter than 2 clk periods may be missed. Master half-period must be at least 3 clk periods.
- RAM storage: 2**NB_DEPTH x NB_BITS, all words initialised to 0. Memory contents are not reset.
- RAM write: if i_ram_wea, mem[i_ram_addr] <= i_ram_data at the clock edge.
- RAM output register, priority order:
  - i_rst -> SSL.
  - else i_ram_flush -> SSL.
  - else i_ram_hold_n -> mem[i_ram_addr].
  - else hold.
- Read-during-write to the same address returns the OLD content (read-first); the new content is visible the following cycle.
- Read latency is 1 clock. The address is used unregistered at the edge.
- The address is full width; no wrap logic is needed.

Optional Feature:
- Macro SPI_LINK_VALID_STROBE_EN.
- Defined: adds output o_valid (1 bit), a 1-cycle pulse in the same cycle o_data is updated by a qualified SCLK rise; reset 0.
- Not defined: port absent; downstream decodes o_data level only.

Test Plan:
- Reset: hold i_rst 4 cycles -> o_data = 0, o_MISO = 0, o_ram_data = SSL (0).
- Capture: cs = 1, i_MOSI = 0x1000FFFF, SCLK pulse of 3 clk high / 3 clk low -> o_data = 0x1000FFFF within 3 clk of the rise. Next word 0x2000F0F0 -> o_data = 0x2000F0F0.
- Response: i_data = 0x000003FF held, SCLK falls -> o_MISO = 0x000003FF within 3 clk. No o_MISO change on the rise.
- Deselect: cs -> 0 after 5 words -> o_data = 0 within 3 clk, o_MISO unchanged. SCLK toggles while cs = 0 -> no change.
- RAM: write 0xFFFFFFFF at addr 0x000, read addr 0x000 with hold_n = 1 -> o_ram_data = 0xFFFFFFFF one cycle later. Simultaneous read/write at same addr -> old value first.
- RAM control: flush = 1 -> o_ram_data = SSL next cycle. hold_n = 0 with address change -> o_ram_data unchanged.
